// File: rtl/d_ff_shift_reg.sv
// Purpose : WIDTH-bit register bank with true/complement outputs, 8 single-cycle
//           operations (hold/shift/rotate/load/preset/invert) and an autonomous burst-shift engine.
// Latency : 1 cycle for every operation; a burst of N shifts keeps busy high for N cycles, then pulses done.
// Backpres: none; while busy, start/en/mode/d/burst_* are ignored. A start in the done cycle is accepted.
//
// Ports:
//   clk, rstn             rising-edge clock, asynchronous active-low reset
//   en, mode, d, si       single-cycle operation enable, select, load data, serial in
//   start, burst_len,     burst request, shift count (0 = immediate done),
//   burst_dir             direction (0 = left, 1 = right)
//   q, q_bar, so          register, its registered complement, last bit shifted/rotated out
//   busy, done            burst in progress, one-cycle completion pulse
module d_ff_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_dir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_r;

    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;

    // Next value of the data path. q_bar is loaded from ~q_nxt on the same edge
    // so the two can never disagree.
    always_comb begin
        q_nxt  = q;
        so_nxt = so;
        if (state == BURST) begin
            if (dir_r) begin
                q_nxt  = {si, q[WIDTH-1:1]};
                so_nxt = q[0];
            end else begin
                q_nxt  = {q[WIDTH-2:0], si};
                so_nxt = q[WIDTH-1];
            end
        end else if (!start && en) begin
            // Any start request in IDLE takes priority over the mode operation.
            case (mode)
                3'b001: begin
                    q_nxt  = {q[WIDTH-2:0], si};
                    so_nxt = q[WIDTH-1];
                end
                3'b010: begin
                    q_nxt  = {si, q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                3'b011: begin
                    q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
                    so_nxt = q[WIDTH-1];
                end
                3'b100: begin
                    q_nxt  = {q[0], q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                3'b101:  q_nxt = d;
                3'b110:  q_nxt = RESET_VAL;
                3'b111:  q_nxt = ~q;
                default: q_nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q     <= RESET_VAL;
            q_bar <= ~RESET_VAL;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            dir_r <= 1'b0;
            state <= IDLE;
        end else begin
            q     <= q_nxt;
            q_bar <= ~q_nxt;
            so    <= so_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            cnt   <= burst_len;
                            dir_r <= burst_dir;
                            busy  <= 1'b1;
                            state <= BURST;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    cnt <= cnt - CNT_W'(1);
                    // cnt==1 here means this edge performs the last shift.
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_ff_shift_reg.sv
module tb_d_ff_shift_reg;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 4;
    localparam logic [7:0] RVAL  = 8'hA5;

    logic             clk;
    logic             rstn;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             si;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             burst_dir;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             so;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    d_ff_shift_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RVAL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .mode     (mode),
        .d        (d),
        .si       (si),
        .start    (start),
        .burst_len(burst_len),
        .burst_dir(burst_dir),
        .q        (q),
        .q_bar    (q_bar),
        .so       (so),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] eq, input logic eso, input logic eb, input logic ed);
        exp_t e;
        e.q = eq; e.so = eso; e.busy = eb; e.done = ed;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0; en = 1'b0; mode = 3'b000; d = '0; si = 1'b0;
        start = 1'b0; burst_len = '0; burst_dir = 1'b0;
        tick();
        rstn = 1'b1;
        // load 81 then shift left so that so=1 and q != reset value
        en = 1'b1; mode = 3'b101; d = 8'h81; tick();
        mode = 3'b001; si = 1'b1; tick();
        en = 1'b0;
        #2;
        rstn = 1'b0;
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        #1;
        e = sb.pop_front();
        checks++; if (q !== e.q)         begin failures++; $display("FAIL reset_q got=%h exp=%h", q, e.q); end
        checks++; if (q_bar !== ~e.q)    begin failures++; $display("FAIL reset_qbar got=%h exp=%h", q_bar, ~e.q); end
        checks++; if (so !== e.so)       begin failures++; $display("FAIL reset_so got=%b exp=%b", so, e.so); end
        checks++; if (busy !== e.busy)   begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, e.busy); end
        checks++; if (done !== e.done)   begin failures++; $display("FAIL reset_done got=%b exp=%b", done, e.done); end
        tick();
        #2;
        rstn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       si;
        logic [7:0] eq;
        logic       eso;
    } op_t;

    task automatic test_modes();
        op_t  ops[12];
        exp_t e;
        ops[0]  = '{1'b1, 3'b101, 8'h81, 1'b0, 8'h81, 1'b0};
        ops[1]  = '{1'b1, 3'b001, 8'h00, 1'b1, 8'h03, 1'b1};
        ops[2]  = '{1'b1, 3'b010, 8'h00, 1'b0, 8'h01, 1'b1};
        ops[3]  = '{1'b1, 3'b100, 8'h00, 1'b0, 8'h80, 1'b1};
        ops[4]  = '{1'b1, 3'b011, 8'h00, 1'b0, 8'h01, 1'b1};
        ops[5]  = '{1'b1, 3'b111, 8'h00, 1'b0, 8'hFE, 1'b1};
        ops[6]  = '{1'b1, 3'b110, 8'h00, 1'b0, 8'hA5, 1'b1};
        ops[7]  = '{1'b0, 3'b111, 8'h00, 1'b0, 8'hA5, 1'b1};
        ops[8]  = '{1'b0, 3'b101, 8'h3C, 1'b1, 8'hA5, 1'b1};
        ops[9]  = '{1'b1, 3'b101, 8'h7E, 1'b0, 8'h7E, 1'b1};
        ops[10] = '{1'b1, 3'b001, 8'h00, 1'b0, 8'hFC, 1'b0};
        ops[11] = '{1'b1, 3'b111, 8'h00, 1'b1, 8'h03, 1'b0};
        for (int i = 0; i < 12; i++) begin
            en = ops[i].en; mode = ops[i].mode; d = ops[i].d; si = ops[i].si;
            push_exp(ops[i].eq, ops[i].eso, 1'b0, 1'b0);
            tick();
            e = sb.pop_front();
            checks++; if (q !== e.q)      begin failures++; $display("FAIL mode_q[%0d] got=%h exp=%h", i, q, e.q); end
            checks++; if (q_bar !== ~e.q) begin failures++; $display("FAIL mode_qbar[%0d] got=%h exp=%h", i, q_bar, ~e.q); end
            checks++; if (so !== e.so)    begin failures++; $display("FAIL mode_so[%0d] got=%b exp=%b", i, so, e.so); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL mode_busy[%0d] got=%b exp=%b", i, busy, e.busy); end
        end
        en = 1'b0;
    endtask

    task automatic test_burst();
        exp_t e;
        logic [7:0] seq[4];
        seq[0] = 8'hE0; seq[1] = 8'hC0; seq[2] = 8'h80; seq[3] = 8'h00;
        en = 1'b1; mode = 3'b101; d = 8'hF0; tick();     // so stays 0 from previous test
        mode = 3'b111; si = 1'b0;
        start = 1'b1; burst_len = 4'd4; burst_dir = 1'b0;
        push_exp(8'hF0, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(seq[i], 1'b1, (i != 3), (i == 3));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (i == 4) en = 1'b0;   // stop the invert before the idle edge
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL burst_q[%0d] got=%h exp=%h", i, q, e.q); end
            checks++; if (q_bar !== ~e.q)  begin failures++; $display("FAIL burst_qbar[%0d] got=%h exp=%h", i, q_bar, ~e.q); end
            checks++; if (so !== e.so)     begin failures++; $display("FAIL burst_so[%0d] got=%b exp=%b", i, so, e.so); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL burst_busy[%0d] got=%b exp=%b", i, busy, e.busy); end
            checks++; if (done !== e.done) begin failures++; $display("FAIL burst_done[%0d] got=%b exp=%b", i, done, e.done); end
        end
        push_exp(8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        checks++; if (q !== e.q)       begin failures++; $display("FAIL burst_after_q got=%h exp=%h", q, e.q); end
        checks++; if (done !== e.done) begin failures++; $display("FAIL burst_after_done got=%b exp=%b", done, e.done); end
    endtask

    task automatic test_abort();
        exp_t e;
        int   done_seen;
        en = 1'b1; mode = 3'b101; d = 8'h00; tick();
        en = 1'b0;
        start = 1'b1; burst_len = 4'd5; burst_dir = 1'b1; si = 1'b1;
        push_exp(8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        // second start with different length/direction, must be ignored
        burst_len = 4'd3; burst_dir = 1'b0;
        push_exp(8'h80, 1'b0, 1'b1, 1'b0);
        push_exp(8'hC0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            if (i == 1) start = 1'b0;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL abort_q[%0d] got=%h exp=%h", i, q, e.q); end
            checks++; if (so !== e.so)     begin failures++; $display("FAIL abort_so[%0d] got=%b exp=%b", i, so, e.so); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL abort_busy[%0d] got=%b exp=%b", i, busy, e.busy); end
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (q !== RVAL)    begin failures++; $display("FAIL abort_rst_q got=%h exp=%h", q, RVAL); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_rst_busy got=%b exp=0", busy); end
        tick();
        #2;
        rstn = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        en = 1'b0; si = 1'b0; burst_dir = 1'b0;
        start = 1'b1; burst_len = 4'd0;
        push_exp(8'hA5, 1'b0, 1'b0, 1'b1);
        push_exp(8'hA5, 1'b0, 1'b1, 1'b0);
        push_exp(8'h4A, 1'b1, 1'b0, 1'b1);
        push_exp(8'h4A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) burst_len = 4'd1;   // start again while done is high
            if (i == 1) start = 1'b0;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL b2b_q[%0d] got=%h exp=%h", i, q, e.q); end
            checks++; if (so !== e.so)     begin failures++; $display("FAIL b2b_so[%0d] got=%b exp=%b", i, so, e.so); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, busy, e.busy); end
            checks++; if (done !== e.done) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done, e.done); end
        end
    endtask

    task automatic test_max_burst();
        int busy_cycles;
        int waited;
        en = 1'b0; si = 1'b0;
        start = 1'b1; burst_len = 4'd15; burst_dir = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            busy_cycles++;
            waited++;
            tick();
        end
        checks++; if (busy_cycles != 15) begin failures++; $display("FAIL max_busy_cycles got=%0d exp=15", busy_cycles); end
        checks++; if (done !== 1'b1)     begin failures++; $display("FAIL max_done got=%b exp=1", done); end
        checks++; if (q !== 8'h00)       begin failures++; $display("FAIL max_q got=%h exp=00", q); end
        tick();
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL max_done_clear got=%b exp=0", done); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_burst();
        test_abort();
        test_back_to_back();
        test_max_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
